clct_cclut_latch: RTL

//  Downstream consumer of the per-CFEB ccLUT best-1-of-32 sorter. Each clock it samples the sorter's best

---
 rtl/clct_cclut_latch.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/clct_cclut_latch.sv
// clct_cclut_latch
// Samples the best pattern/key/comparator code from the per-CFEB ccLUT sorter
// every clock, qualifies it against hit and pattern-ID thresholds, applies a
// programmable trigger dead time and buffers accepted CLCTs in a small
// first-word-fall-through FIFO that the readout logic drains via valid/read.
//
// Ports
//   clock_i       system clock
//   reset_i       asynchronous active-high reset
//   best_pat_i    best pattern: [6:4] layer hits, [3:0] pattern ID
//   best_key_i    best key 1/2-strip within this CFEB
//   best_carry_i  best comparator code
//   cfeb_id_i     static CFEB index, prepended to the key
//   hit_thresh_i  minimum layer hit count
//   pid_thresh_i  minimum pattern ID
//   dead_time_i   trigger dead time in clocks, 0 = none
//   clct_rd_i     pop the head entry (ignored while empty)
//   clct_vld_o    FIFO not empty
//   clct_word_o   head entry {cfeb_id,key,pat,carry}, 0 when empty
//   fifo_full_o   FIFO holds FIFO_DEPTH entries
//   trig_cnt_o    accepted-trigger count, saturating
//   ovf_cnt_o     dropped-trigger count, saturating
module clct_cclut_latch #(
    parameter int MXPATB     = 7,
    parameter int MXKEYB     = 5,
    parameter int MXPATC     = 11,
    parameter int MXCFEBB    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int MXWORD     = MXCFEBB + MXKEYB + MXPATB + MXPATC
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [MXPATB-1:0]   best_pat_i,
    input  logic [MXKEYB-1:0]   best_key_i,
    input  logic [MXPATC-1:0]   best_carry_i,
    input  logic [MXCFEBB-1:0]  cfeb_id_i,
    input  logic [2:0]          hit_thresh_i,
    input  logic [3:0]          pid_thresh_i,
    input  logic [3:0]          dead_time_i,
    input  logic                clct_rd_i,
    output logic                clct_vld_o,
    output logic [MXWORD-1:0]   clct_word_o,
    output logic                fifo_full_o,
    output logic [15:0]         trig_cnt_o,
    output logic [7:0]          ovf_cnt_o
);

    localparam int PTRB = $clog2(FIFO_DEPTH);
    localparam int CNTB = PTRB + 1;

    typedef enum logic {
        IDLE = 1'b0,
        DEAD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         dead_cnt_q, dead_cnt_d;

    logic [MXWORD-1:0]  mem_q [FIFO_DEPTH];
    logic [PTRB-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNTB-1:0]    occ_q;
    logic [15:0]        trig_cnt_q;
    logic [7:0]         ovf_cnt_q;

    logic               qualify;
    logic               trigger;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [MXWORD-1:0]  new_word;

    // A pattern with zero layer hits is never a trigger, even with both
    // thresholds at zero.
    assign qualify = (best_pat_i[6:4] != 3'd0)
                   & (best_pat_i[6:4] >= hit_thresh_i)
                   & (best_pat_i[3:0] >= pid_thresh_i);

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == CNTB'(FIFO_DEPTH));
    assign pop        = clct_rd_i & ~fifo_empty;

    // A full FIFO can still accept a trigger when the head leaves at the same
    // edge; only a full FIFO with no pop drops the entry.
    assign push = trigger & (~fifo_full | pop);
    assign drop = trigger & fifo_full & ~pop;

    assign new_word = {cfeb_id_i, best_key_i, best_pat_i, best_carry_i};

    // Dead-time state register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            dead_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    // Next-state logic. The dead count is latched once at the trigger, so
    // later dead_time changes do not stretch or shorten a running window.
    // Leaving DEAD on the clock the count reads 1 blocks exactly dead_time
    // edges after the trigger.
    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        trigger    = 1'b0;
        case (state_q)
            IDLE: begin
                if (qualify) begin
                    trigger    = 1'b1;
                    dead_cnt_d = dead_time_i;
                    if (dead_time_i != 4'd0) begin
                        state_d = DEAD;
                    end
                end
            end
            DEAD: begin
                dead_cnt_d = dead_cnt_q - 4'd1;
                if (dead_cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                dead_cnt_d = 4'd0;
            end
        endcase
    end

    // FIFO storage and pointers; pointers wrap naturally because the depth
    // is a power of two.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= new_word;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                occ_q <= occ_q + CNTB'(1);
            end else if (pop && !push) begin
                occ_q <= occ_q - CNTB'(1);
            end
        end
    end

    // Saturating accepted/dropped trigger counters.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            trig_cnt_q <= 16'd0;
            ovf_cnt_q  <= 8'd0;
        end else begin
            if (push && (trig_cnt_q != 16'hFFFF)) begin
                trig_cnt_q <= trig_cnt_q + 16'd1;
            end
            if (drop && (ovf_cnt_q != 8'hFF)) begin
                ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end
        end
    end

    assign clct_vld_o  = ~fifo_empty;
    assign clct_word_o = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_full_o = fifo_full;
    assign trig_cnt_o  = trig_cnt_q;
    assign ovf_cnt_o   = ovf_cnt_q;

endmodule
